sram_arbiter: RTL and testbench

Arbitrates a single asynchronous 32-bit external SRAM (20-bit word address, active-low controls) between two requesters: the instruction-fetch port (read-only) and the data port (read/write with byte enables). Each granted access is sequenced through fixed setup/strobe/recovery phases. The block sits between the CPU memory stages and the board SRAM pins. Tristate buffering is done at the top level.

---
 rtl/sram_pkg.sv | 49 ++++
 rtl/sram_rr_arbiter2.sv | 35 +++
 rtl/sram_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_sram_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared constants, state encoding and pin bundle for the external SRAM arbiter.
package sram_pkg;

  localparam int SRAM_AW       = 20;
  localparam int SRAM_DW       = 32;
  localparam int SRAM_BW       = SRAM_DW / 8;
  localparam int RD_CYCLES_DEF = 2;
  localparam int WR_CYCLES_DEF = 2;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_STROBE = 3'd1,
    ST_RD_END    = 3'd2,
    ST_WR_SETUP  = 3'd3,
    ST_WR_STROBE = 3'd4,
    ST_WR_HOLD   = 3'd5
  } state_e;

  typedef struct packed {
    logic [SRAM_AW-1:0] addr;
    logic [SRAM_DW-1:0] dout;
    logic [SRAM_BW-1:0] be_n;
    logic               ce_n;
    logic               oe_n;
    logic               we_n;
    logic               dout_oe;
  } pins_t;

  localparam pins_t PINS_RESET = '{
    addr:    '0,
    dout:    '0,
    be_n:    '1,
    ce_n:    1'b1,
    oe_n:    1'b1,
    we_n:    1'b1,
    dout_oe: 1'b0
  };

  // Strobe counter only has to reach the longer of the two strobe lengths minus one.
  function automatic int cnt_width(int rd_cycles, int wr_cycles);
    int longest;
    longest = (rd_cycles > wr_cycles) ? rd_cycles : wr_cycles;
    return (longest < 2) ? 1 : $clog2(longest);
  endfunction

endpackage

// File: rtl/sram_rr_arbiter2.sv
// Two-input round-robin grant: combinational choice, last winner remembered on accept.
module sram_rr_arbiter2
  import sram_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req_if,
  input  logic i_req_d,
  input  logic i_accept,
  output logic o_gnt_valid,
  output logic o_gnt_port
);

  logic r_last_grant;

  always_comb begin
    o_gnt_valid = i_req_if | i_req_d;
    o_gnt_port  = PORT_IF;
    if (i_req_if && i_req_d) begin
      o_gnt_port = ~r_last_grant;
    end else if (i_req_d) begin
      o_gnt_port = PORT_D;
    end
  end

  // Starting from "fetch won last" makes the first tie after reset go to data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= PORT_IF;
    end else if (i_accept && o_gnt_valid) begin
      r_last_grant <= o_gnt_port;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Fetch/data arbiter and access sequencer for one asynchronous 32-bit SRAM.
// Every pin and done pulse is a flop; tristate buffering lives one level up.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int RD_CYCLES = RD_CYCLES_DEF,
  parameter int WR_CYCLES = WR_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_if_req,
  input  logic [SRAM_AW-1:0] i_if_addr,
  output logic               o_if_done,
  output logic [SRAM_DW-1:0] o_if_rdata,
  input  logic               i_d_req,
  input  logic               i_d_we,
  input  logic [SRAM_AW-1:0] i_d_addr,
  input  logic [SRAM_BW-1:0] i_d_be,
  input  logic [SRAM_DW-1:0] i_d_wdata,
  output logic               o_d_done,
  output logic [SRAM_DW-1:0] o_d_rdata,
  output logic [SRAM_AW-1:0] o_sram_addr,
  input  logic [SRAM_DW-1:0] i_sram_din,
  output logic [SRAM_DW-1:0] o_sram_dout,
  output logic               o_sram_dout_oe,
  output logic               o_sram_ce_n,
  output logic               o_sram_oe_n,
  output logic               o_sram_we_n,
  output logic [SRAM_BW-1:0] o_sram_be_n
);

  localparam int               CNT_W   = cnt_width(RD_CYCLES, WR_CYCLES);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);

  state_e             r_state,    w_state_nxt;
  logic [CNT_W-1:0]   r_cnt,      w_cnt_nxt;
  pins_t              r_pins,     w_pins_nxt;
  logic               r_port,     w_port_nxt;
  logic               r_if_done,  w_if_done_nxt;
  logic               r_d_done,   w_d_done_nxt;
  logic [SRAM_DW-1:0] r_if_rdata, w_if_rdata_nxt;
  logic [SRAM_DW-1:0] r_d_rdata,  w_d_rdata_nxt;

  logic w_gnt_valid;
  logic w_gnt_port;
  logic w_accept;

  assign w_accept = (r_state == ST_IDLE);

  sram_rr_arbiter2 u_rr (
    .clk         (clk),
    .rst         (rst),
    .i_req_if    (i_if_req),
    .i_req_d     (i_d_req),
    .i_accept    (w_accept),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_port  (w_gnt_port)
  );

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_pins_nxt     = r_pins;
    w_port_nxt     = r_port;
    w_if_done_nxt  = 1'b0;
    w_d_done_nxt   = 1'b0;
    w_if_rdata_nxt = r_if_rdata;
    w_d_rdata_nxt  = r_d_rdata;

    unique case (r_state)
      ST_IDLE: begin
        w_pins_nxt.ce_n    = 1'b1;
        w_pins_nxt.oe_n    = 1'b1;
        w_pins_nxt.we_n    = 1'b1;
        w_pins_nxt.dout_oe = 1'b0;
        w_pins_nxt.be_n    = '1;
        if (w_gnt_valid) begin
          w_port_nxt      = w_gnt_port;
          w_cnt_nxt       = '0;
          w_pins_nxt.ce_n = 1'b0;
          w_pins_nxt.addr = (w_gnt_port == PORT_D) ? i_d_addr : i_if_addr;
          // Fetch never writes, whatever d_we happens to be.
          if ((w_gnt_port == PORT_D) && i_d_we) begin
            w_state_nxt        = ST_WR_SETUP;
            w_pins_nxt.dout    = i_d_wdata;
            w_pins_nxt.be_n    = ~i_d_be;
            w_pins_nxt.dout_oe = 1'b1;
          end else begin
            w_state_nxt     = ST_RD_STROBE;
            w_pins_nxt.oe_n = 1'b0;
            w_pins_nxt.be_n = '0;
          end
        end
      end

      ST_RD_STROBE: begin
        if (r_cnt == RD_LAST) begin
          w_state_nxt     = ST_RD_END;
          w_pins_nxt.ce_n = 1'b1;
          w_pins_nxt.oe_n = 1'b1;
          w_pins_nxt.be_n = '1;
          if (r_port == PORT_D) begin
            w_d_rdata_nxt = i_sram_din;
            w_d_done_nxt  = 1'b1;
          end else begin
            w_if_rdata_nxt = i_sram_din;
            w_if_done_nxt  = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      ST_RD_END: begin
        w_state_nxt = ST_IDLE;
      end

      ST_WR_SETUP: begin
        w_state_nxt     = ST_WR_STROBE;
        w_cnt_nxt       = '0;
        w_pins_nxt.we_n = 1'b0;
      end

      ST_WR_STROBE: begin
        if (r_cnt == WR_LAST) begin
          w_state_nxt     = ST_WR_HOLD;
          w_pins_nxt.we_n = 1'b1;
          w_pins_nxt.ce_n = 1'b1;
          w_d_done_nxt    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      ST_WR_HOLD: begin
        // Data stays driven through hold so it outlasts the we_n rising edge.
        w_state_nxt        = ST_IDLE;
        w_pins_nxt.dout_oe = 1'b0;
        w_pins_nxt.be_n    = '1;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_pins     <= PINS_RESET;
      r_port     <= PORT_IF;
      r_if_done  <= 1'b0;
      r_d_done   <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pins     <= w_pins_nxt;
      r_port     <= w_port_nxt;
      r_if_done  <= w_if_done_nxt;
      r_d_done   <= w_d_done_nxt;
      r_if_rdata <= w_if_rdata_nxt;
      r_d_rdata  <= w_d_rdata_nxt;
    end
  end

  assign o_if_done      = r_if_done;
  assign o_if_rdata     = r_if_rdata;
  assign o_d_done       = r_d_done;
  assign o_d_rdata      = r_d_rdata;
  assign o_sram_addr    = r_pins.addr;
  assign o_sram_dout    = r_pins.dout;
  assign o_sram_dout_oe = r_pins.dout_oe;
  assign o_sram_ce_n    = r_pins.ce_n;
  assign o_sram_oe_n    = r_pins.oe_n;
  assign o_sram_we_n    = r_pins.we_n;
  assign o_sram_be_n    = r_pins.be_n;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench: two arbiters (RD/WR = 2/2 and 1/3), each on its own SRAM model.
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        if_req  [2];
  logic [19:0] if_addr [2];
  logic        if_done [2];
  logic [31:0] if_rdata[2];
  logic        d_req   [2];
  logic        d_we    [2];
  logic [19:0] d_addr  [2];
  logic [3:0]  d_be    [2];
  logic [31:0] d_wdata [2];
  logic        d_done  [2];
  logic [31:0] d_rdata [2];
  logic [19:0] sram_addr[2];
  logic [31:0] sram_din [2];
  logic [31:0] sram_dout[2];
  logic        dout_oe  [2];
  logic        ce_n     [2];
  logic        oe_n     [2];
  logic        we_n     [2];
  logic [3:0]  be_n     [2];

  sram_arbiter #(.RD_CYCLES(2), .WR_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst),
    .i_if_req(if_req[0]), .i_if_addr(if_addr[0]), .o_if_done(if_done[0]), .o_if_rdata(if_rdata[0]),
    .i_d_req(d_req[0]), .i_d_we(d_we[0]), .i_d_addr(d_addr[0]), .i_d_be(d_be[0]),
    .i_d_wdata(d_wdata[0]), .o_d_done(d_done[0]), .o_d_rdata(d_rdata[0]),
    .o_sram_addr(sram_addr[0]), .i_sram_din(sram_din[0]), .o_sram_dout(sram_dout[0]),
    .o_sram_dout_oe(dout_oe[0]), .o_sram_ce_n(ce_n[0]), .o_sram_oe_n(oe_n[0]),
    .o_sram_we_n(we_n[0]), .o_sram_be_n(be_n[0])
  );

  sram_arbiter #(.RD_CYCLES(1), .WR_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst),
    .i_if_req(if_req[1]), .i_if_addr(if_addr[1]), .o_if_done(if_done[1]), .o_if_rdata(if_rdata[1]),
    .i_d_req(d_req[1]), .i_d_we(d_we[1]), .i_d_addr(d_addr[1]), .i_d_be(d_be[1]),
    .i_d_wdata(d_wdata[1]), .o_d_done(d_done[1]), .o_d_rdata(d_rdata[1]),
    .o_sram_addr(sram_addr[1]), .i_sram_din(sram_din[1]), .o_sram_dout(sram_dout[1]),
    .o_sram_dout_oe(dout_oe[1]), .o_sram_ce_n(ce_n[1]), .o_sram_oe_n(oe_n[1]),
    .o_sram_we_n(we_n[1]), .o_sram_be_n(be_n[1])
  );

  function automatic int rdc(int g); return (g == 0) ? 2 : 1; endfunction
  function automatic int wrc(int g); return (g == 0) ? 2 : 3; endfunction

  // ---------------- scoreboard and counters ----------------
  typedef struct {
    int          inst;
    bit          port;   // 0 = fetch, 1 = data
    bit          chk;    // compare read data
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  bit   log0[$];
  int   total = 0;
  int   bad   = 0;

  logic [3:0]  exp_be_n [2];
  logic [31:0] exp_dout [2];
  logic [19:0] exp_waddr[2];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- SRAM models and reference memory ----------------
  logic [31:0] sram_mem[bit [20:0]];
  logic [31:0] ref_mem [bit [20:0]];

  function automatic logic [31:0] init_word(logic [19:0] a);
    return {12'h5A5, a};
  endfunction

  function automatic logic [31:0] sram_read(int g, logic [19:0] a);
    bit [20:0] k = {g[0], a};
    return sram_mem.exists(k) ? sram_mem[k] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_read(int g, logic [19:0] a);
    bit [20:0] k = {g[0], a};
    return ref_mem.exists(k) ? ref_mem[k] : init_word(a);
  endfunction

  function automatic void ref_write(int g, logic [19:0] a, logic [3:0] be, logic [31:0] wd);
    logic [31:0] w = ref_read(g, a);
    for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
    ref_mem[{g[0], a}] = w;
  endfunction

  // Asynchronous read path: data is valid half a cycle after the pins settle.
  always begin
    @(negedge clk);
    for (int g = 0; g < 2; g++)
      sram_din[g] = (!ce_n[g] && !oe_n[g]) ? sram_read(g, sram_addr[g]) : 32'hDEAD_BEEF;
  end

  always begin
    @(posedge clk);
    for (int g = 0; g < 2; g++) begin
      if (!rst && !ce_n[g] && !we_n[g]) begin
        logic [31:0] w;
        w = sram_read(g, sram_addr[g]);
        for (int b = 0; b < 4; b++) if (!be_n[g][b]) w[b*8 +: 8] = sram_dout[g][b*8 +: 8];
        sram_mem[{g[0], sram_addr[g]}] = w;
      end
    end
  end

  // ---------------- monitor ----------------
  int oe_len[2];
  int we_len[2];
  int ce_hi [2];
  bit p_if  [2];
  bit p_d   [2];

  always begin
    bit          dn;
    logic [31:0] rd;
    int          idx;
    @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        oe_len[g] = 0; we_len[g] = 0; ce_hi[g] = 2; p_if[g] = 0; p_d[g] = 0;
      end else begin
        if (if_done[g] || d_done[g]) check("done_overlap", {31'd0, if_done[g] & d_done[g]}, 0);
        if (if_done[g] && p_if[g]) check("if_done_width", 2, 1);
        if (d_done[g] && p_d[g]) check("d_done_width", 2, 1);
        p_if[g] = if_done[g];
        p_d[g]  = d_done[g];
        for (int p = 0; p < 2; p++) begin
          dn = (p == 1) ? d_done[g] : if_done[g];
          rd = (p == 1) ? d_rdata[g] : if_rdata[g];
          if (dn) begin
            idx = -1;
            foreach (sb[i]) if (idx < 0 && sb[i].inst == g && sb[i].port == p[0]) idx = i;
            if (idx < 0) begin
              check("unexpected_done", {30'd0, g[0], p[0]}, 32'hFFFF_FFFF);
            end else begin
              if (sb[idx].chk) check((p == 1) ? "d_rdata" : "if_rdata", rd, sb[idx].data);
              sb.delete(idx);
              if (g == 0) log0.push_back(p[0]);
            end
          end
        end
        if (!oe_n[g]) begin
          check("dout_oe_during_read", {31'd0, dout_oe[g]}, 0);
          check("we_n_during_read", {31'd0, we_n[g]}, 1);
          check("be_n_during_read", {28'd0, be_n[g]}, 0);
          oe_len[g]++;
        end else if (oe_len[g] > 0) begin
          check("oe_n_low_cycles", oe_len[g], rdc(g));
          oe_len[g] = 0;
        end
        if (!we_n[g]) begin
          check("dout_oe_during_write", {31'd0, dout_oe[g]}, 1);
          check("be_n_during_write", {28'd0, be_n[g]}, {28'd0, exp_be_n[g]});
          check("dout_during_write", sram_dout[g], exp_dout[g]);
          check("addr_during_write", {12'd0, sram_addr[g]}, {12'd0, exp_waddr[g]});
          we_len[g]++;
        end else if (we_len[g] > 0) begin
          check("we_n_low_cycles", we_len[g], wrc(g));
          we_len[g] = 0;
        end
        // An access ending (ce_n high) plus one IDLE cycle gives at least two high samples.
        if (ce_n[g]) begin
          ce_hi[g]++;
        end else begin
          if (ce_hi[g] > 0) check("idle_gap_ok", {31'd0, ce_hi[g] >= 2}, 1);
          ce_hi[g] = 0;
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic do_fetch(int g, logic [19:0] a, bit lat);
    int n = 0;
    exp_t e;
    e = '{inst: g, port: 1'b0, chk: 1'b1, data: ref_read(g, a)};
    sb.push_back(e);
    if (lat) repeat (2) @(negedge clk); else @(negedge clk);
    if_addr[g] = a;
    if_req[g]  = 1'b1;
    do begin @(posedge clk); #1; n++; end while (!if_done[g] && n < 40);
    if_req[g] = 1'b0;
    if (!if_done[g]) check("fetch_timeout", n, 0);
    else if (lat) check("fetch_latency", n, rdc(g) + 1);
  endtask

  task automatic do_data(int g, bit we, logic [19:0] a, logic [3:0] be, logic [31:0] wd,
                         bit lat, bit drop_early);
    int n = 0;
    exp_t e;
    if (we) begin
      e = '{inst: g, port: 1'b1, chk: 1'b0, data: 32'd0};
      exp_be_n[g]  = ~be;
      exp_dout[g]  = wd;
      exp_waddr[g] = a;
      ref_write(g, a, be, wd);
    end else begin
      e = '{inst: g, port: 1'b1, chk: 1'b1, data: ref_read(g, a)};
    end
    sb.push_back(e);
    if (lat) repeat (2) @(negedge clk); else @(negedge clk);
    d_we[g] = we; d_addr[g] = a; d_be[g] = be; d_wdata[g] = wd;
    d_req[g] = 1'b1;
    do begin
      @(posedge clk); #1; n++;
      if (drop_early && n == 1) begin
        d_req[g] = 1'b0; d_we[g] = ~we; d_addr[g] = ~a; d_be[g] = ~be; d_wdata[g] = ~wd;
      end
    end while (!d_done[g] && n < 40);
    d_req[g] = 1'b0;
    if (!d_done[g]) check("data_timeout", n, 0);
    else if (lat) check(we ? "write_latency" : "dread_latency", n, we ? wrc(g) + 2 : rdc(g) + 1);
  endtask

  task automatic rand_fetch(int g, int cnt);
    for (int i = 0; i < cnt; i++) do_fetch(g, 20'($urandom_range(0, 15)), 1'b0);
  endtask

  task automatic rand_data(int g, int cnt);
    for (int i = 0; i < cnt; i++) begin
      logic [19:0] a  = 20'h100 + 20'($urandom_range(0, 15));
      bit          we = 1'($urandom_range(0, 1));
      logic [3:0]  be = 4'($urandom_range(0, 15));
      logic [31:0] wd = $urandom;
      do_data(g, we, a, be, wd, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      if_req[g] = 0; if_addr[g] = '0; d_req[g] = 0; d_we[g] = 0;
      d_addr[g] = '0; d_be[g] = '0; d_wdata[g] = '0;
      exp_be_n[g] = '1; exp_dout[g] = '0; exp_waddr[g] = '0;
      sram_mem[{g[0], 20'h00010}] = 32'h2402_0001;
      ref_mem [{g[0], 20'h00010}] = 32'h2402_0001;
      sram_mem[{g[0], 20'h00100}] = 32'h1122_3344;
      ref_mem [{g[0], 20'h00100}] = 32'h1122_3344;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check("reset_ctrl", {24'd0, ce_n[g], oe_n[g], we_n[g], dout_oe[g], be_n[g]}, 32'h0000_00EF);
      check("reset_addr", {12'd0, sram_addr[g]}, 0);
      check("reset_dout", sram_dout[g], 0);
      check("reset_done", {30'd0, if_done[g], d_done[g]}, 0);
      check("reset_rdata", if_rdata[g] | d_rdata[g], 0);
    end
    rst = 1'b0;

    // Single fetch, then byte-lane write and read-back.
    do_fetch(0, 20'h00010, 1'b1);
    check("ce_n_in_done_cycle", {31'd0, ce_n[0]}, 1);
    do_data(0, 1'b1, 20'h00100, 4'b0011, 32'hAABB_CCDD, 1'b1, 1'b0);
    do_data(0, 1'b0, 20'h00100, 4'b0000, 32'h0, 1'b1, 1'b0);
    do_data(0, 1'b1, 20'h00100, 4'b0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    do_data(0, 1'b0, 20'h00100, 4'b0000, 32'h0, 1'b1, 1'b0);
    check("if_rdata_held", if_rdata[0], 32'h2402_0001);

    // Requester drops req (and scrambles its inputs) right after grant.
    do_data(0, 1'b0, 20'h00104, 4'b0000, 32'h0, 1'b1, 1'b1);
    do_data(0, 1'b1, 20'h00108, 4'b1111, 32'h1234_5678, 1'b1, 1'b1);
    lows = 0;
    repeat (6) begin @(posedge clk); #1; if (!ce_n[0]) lows++; end
    check("no_extra_access", lows, 0);
    do_data(0, 1'b0, 20'h00108, 4'b0000, 32'h0, 1'b1, 1'b0);

    // Async reset in the middle of a write strobe.
    @(negedge clk);
    exp_be_n[0] = 4'h0; exp_dout[0] = 32'h5555_AAAA; exp_waddr[0] = 20'h001F0;
    d_we[0] = 1'b1; d_addr[0] = 20'h001F0; d_be[0] = 4'hF; d_wdata[0] = 32'h5555_AAAA;
    d_req[0] = 1'b1;
    lows = 0;
    do begin @(posedge clk); #1; lows++; end while (we_n[0] && lows < 20);
    check("reached_wr_strobe", {31'd0, we_n[0]}, 0);
    #2 rst = 1'b1;
    d_req[0] = 1'b0;
    #1;
    check("async_rst_pins", {28'd0, we_n[0], ce_n[0], dout_oe[0], d_done[0]}, 32'h0000_000C);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_fetch(0, 20'h00010, 1'b1);

    // Both requesters held: D, IF, D, IF.
    log0.delete();
    fork
      begin do_fetch(0, 20'h00011, 1'b0); do_fetch(0, 20'h00012, 1'b0); end
      begin
        do_data(0, 1'b1, 20'h00110, 4'hF, 32'hCAFE_0001, 1'b0, 1'b0);
        do_data(0, 1'b0, 20'h00110, 4'h0, 32'h0, 1'b0, 1'b0);
      end
    join
    check("rr_count", log0.size(), 4);
    if (log0.size() == 4) begin
      check("rr_order0", {31'd0, log0[0]}, 1);
      check("rr_order1", {31'd0, log0[1]}, 0);
      check("rr_order2", {31'd0, log0[2]}, 1);
      check("rr_order3", {31'd0, log0[3]}, 0);
    end

    // Short-read / long-write instance, then random back-to-back traffic on both.
    do_fetch(1, 20'h00010, 1'b1);
    do_data(1, 1'b1, 20'h00100, 4'b1000, 32'h99AB_CDEF, 1'b1, 1'b0);
    do_data(1, 1'b0, 20'h00100, 4'b0000, 32'h0, 1'b1, 1'b0);
    fork
      rand_fetch(1, 10);
      rand_data (1, 10);
      rand_fetch(0, 10);
      rand_data (0, 10);
    join

    lows = 0;
    while (sb.size() != 0 && lows < 20) begin @(posedge clk); lows++; end
    check("scoreboard_empty", sb.size(), 0);
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
